// File: rtl/tlul_slave_mem.sv
// TL-UL slave memory: word-addressed RAM behind one outstanding A/D transaction, 1-cycle response latency.
// a_ready drops on accept and returns the cycle after the D handshake; d_* held while d_ready is low.
module tlul_slave_mem #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    SRC_WIDTH  = 1,
   parameter int                    SINK_WIDTH = 1,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
   parameter int                    MEM_DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      a_valid,
   input  logic [2:0]                a_opcode,
   input  logic [2:0]                a_param,
   input  logic [2:0]                a_size,
   input  logic [SRC_WIDTH-1:0]      a_source,
   input  logic [ADDR_WIDTH-1:0]     a_address,
   input  logic [DATA_WIDTH/8-1:0]   a_mask,
   input  logic [DATA_WIDTH-1:0]     a_data,
   output logic                      a_ready,
   output logic                      d_valid,
   output logic [2:0]                d_opcode,
   output logic [2:0]                d_param,
   output logic [2:0]                d_size,
   output logic [SRC_WIDTH-1:0]      d_source,
   output logic [SINK_WIDTH-1:0]     d_sink,
   output logic [DATA_WIDTH-1:0]     d_data,
   output logic                      d_error,
   input  logic                      d_ready
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
   // One extra bit keeps the upper bound from wrapping when the window ends at the top of the space.
   localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

   localparam logic [2:0] OP_PUT_FULL     = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
   localparam logic [2:0] OP_GET          = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef enum logic {IDLE, RESP} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  a_fire;
   logic                  is_put_full;
   logic                  is_put_part;
   logic                  is_get;
   logic                  supported;
   logic                  in_range;
   logic                  aligned;
   logic                  req_error;
   logic                  write_en;
   logic [IDX_WIDTH-1:0]  word_idx;
   logic [2:0]            unused_a_param;

   assign unused_a_param = a_param;

   assign a_fire      = a_valid & a_ready;
   assign is_put_full = (a_opcode == OP_PUT_FULL);
   assign is_put_part = (a_opcode == OP_PUT_PARTIAL);
   assign is_get      = (a_opcode == OP_GET);
   assign supported   = is_put_full | is_put_part | is_get;
   assign in_range    = ({1'b0, a_address} >= BASE_EXT) && ({1'b0, a_address} < LIMIT_EXT);
   assign word_idx    = a_address[2 +: IDX_WIDTH];

   always_comb begin
      aligned = 1'b0;
      case (a_size)
         3'd0:    aligned = 1'b1;
         3'd1:    aligned = ~a_address[0];
         3'd2:    aligned = (a_address[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign req_error = ~supported | ~in_range | ~aligned | (is_put_full & ~(&a_mask));
   assign write_en  = a_fire & (is_put_full | is_put_part) & ~req_error;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (write_en) begin
         // A valid PutFullData always carries a full mask, so byte enables cover both puts.
         for (int b = 0; b < MASK_WIDTH; b++)
            if (a_mask[b]) mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         a_ready  <= 1'b0;
         d_valid  <= 1'b0;
         d_opcode <= '0;
         d_param  <= '0;
         d_size   <= '0;
         d_source <= '0;
         d_sink   <= '0;
         d_data   <= '0;
         d_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               a_ready <= 1'b1;
               if (a_fire) begin
                  state    <= RESP;
                  a_ready  <= 1'b0;
                  d_valid  <= 1'b1;
                  d_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                  d_param  <= '0;
                  d_sink   <= '0;
                  d_size   <= a_size;
                  d_source <= a_source;
                  d_error  <= req_error;
                  d_data   <= (is_get && !req_error) ? mem[word_idx] : '0;
               end
            end
            RESP: begin
               if (d_ready) begin
                  state   <= IDLE;
                  d_valid <= 1'b0;
                  a_ready <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               d_valid <= 1'b0;
               a_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tlul_slave_mem.sv
// Randomized bench for tlul_slave_mem: a per-transaction reference model predicts every D response,
// and a compare process checks handshake and response outputs on each falling edge.
module tb_tlul_slave_mem;
   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid;
   logic [2:0]  a_opcode, a_param, a_size;
   logic [0:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        a_ready;
   logic        d_valid;
   logic [2:0]  d_opcode, d_param, d_size;
   logic [0:0]  d_source, d_sink;
   logic [31:0] d_data;
   logic        d_error;
   logic        d_ready;

   int checks   = 0;
   int failures = 0;

   // reference state
   logic [31:0] mem_m [16];
   logic        exp_a_ready, exp_d_valid, fields_known;
   logic [2:0]  exp_opcode, exp_size;
   logic        exp_source, exp_error;
   logic [31:0] exp_data;

   logic [2:0]  last_opcode;
   logic [31:0] last_data;
   logic        last_error, last_source;

   tlul_slave_mem dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .a_ready(a_ready),
      .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
      .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
      .d_ready(d_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_a_ready  = 1'b0;
      exp_d_valid  = 1'b0;
      fields_known = 1'b1;
      exp_opcode   = 3'd0;
      exp_size     = 3'd0;
      exp_source   = 1'b0;
      exp_error    = 1'b0;
      exp_data     = 32'd0;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
   endtask

   // What a slave memory at 0x1000..0x103F must answer, applied at the accept edge.
   task automatic model_accept(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                               input logic [3:0] mask, input logic [31:0] data, input logic src);
      bit supported, in_range, aligned, bad;
      int idx;
      supported = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
      in_range  = (addr >= 32'h1000) && (addr < 32'h1040);
      aligned   = (size == 3'd0) || (size == 3'd1 && addr % 2 == 0) || (size == 3'd2 && addr % 4 == 0);
      bad       = !in_range || !aligned || (op == 3'd0 && mask != 4'hF);
      idx       = (addr - 32'h1000) / 4;
      exp_a_ready  = 1'b0;
      exp_d_valid  = 1'b1;
      fields_known = 1'b1;
      exp_size     = size;
      exp_source   = src;
      exp_data     = 32'd0;
      if (!supported) begin
         exp_opcode = 3'd0;
         exp_error  = 1'b1;
      end else if (op == 3'd4) begin
         exp_opcode = 3'd1;
         exp_error  = bad;
         if (!bad) exp_data = mem_m[idx];
      end else begin
         exp_opcode = 3'd0;
         exp_error  = bad;
         if (!bad)
            for (int b = 0; b < 4; b++)
               if (op == 3'd0 || mask[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("a_ready", a_ready, exp_a_ready);
         chk("d_valid", d_valid, exp_d_valid);
         if (exp_d_valid || fields_known) begin
            chk("d_opcode", d_opcode, exp_opcode);
            chk("d_param", d_param, 3'd0);
            chk("d_size", d_size, exp_size);
            chk("d_source", d_source, exp_source);
            chk("d_sink", d_sink, 1'b0);
            chk("d_data", d_data, exp_data);
            chk("d_error", d_error, exp_error);
         end
      end
   end

   // Entered at posedge+1 with a_ready expected high; returns at posedge+1 after the D handshake.
   task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic src,
                         input int stall, input bit junk);
      a_valid   = 1'b1;
      a_opcode  = op;
      a_param   = 3'($urandom);
      a_size    = size;
      a_mask    = mask;
      a_address = addr;
      a_data    = data;
      a_source  = src;
      d_ready   = 1'b0;
      @(posedge clk); #1;
      model_accept(op, addr, size, mask, data, src);
      a_valid = junk;
      if (junk) begin
         a_opcode  = 3'd0;
         a_size    = 3'd2;
         a_mask    = 4'hF;
         a_address = 32'h1000 + 4 * $urandom_range(0, 15);
         a_data    = $urandom;
      end
      @(negedge clk);
      chk("latency_d_valid", d_valid, 1'b1);
      last_opcode = d_opcode;
      last_data   = d_data;
      last_error  = d_error;
      last_source = d_source;
      repeat (stall) @(negedge clk);
      d_ready = 1'b1;
      @(posedge clk); #1;
      exp_d_valid  = 1'b0;
      exp_a_ready  = 1'b1;
      fields_known = 1'b0;
      d_ready      = 1'b0;
      a_valid      = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : driver
      logic [2:0]  op, sz;
      logic [31:0] ad;
      logic [3:0]  mk;
      int r;
      reset = 1'b0;
      a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
      a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      fields_known = 1'b0;
      @(posedge clk); #1;
      exp_a_ready = 1'b1;
      chk("a_ready_after_reset", a_ready, 1'b1);

      do_txn(3'd0, 32'h1000, 3'd2, 4'hF, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
      chk("put_full_opcode", last_opcode, 3'd0);
      chk("put_full_error", last_error, 1'b0);
      do_txn(3'd4, 32'h1000, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("get_opcode", last_opcode, 3'd1);
      chk("get_data", last_data, 32'hA5A5_A5A5);
      chk("get_error", last_error, 1'b0);

      do_txn(3'd0, 32'h1004, 3'd2, 4'hF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      do_txn(3'd1, 32'h1004, 3'd2, 4'b0011, 32'h1234_5678, 1'b0, 0, 1'b0);
      do_txn(3'd4, 32'h1004, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("partial_merge", last_data, 32'hFFFF_5678);

      do_txn(3'd4, 32'h2000, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("oor_get_opcode", last_opcode, 3'd1);
      chk("oor_get_error", last_error, 1'b1);
      chk("oor_get_data", last_data, 32'h0);
      do_txn(3'd4, 32'h103C, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("last_word_error", last_error, 1'b0);
      do_txn(3'd0, 32'h1000, 3'd2, 4'b0111, 32'h0BAD_0BAD, 1'b0, 0, 1'b0);
      chk("bad_mask_error", last_error, 1'b1);
      do_txn(3'd4, 32'h1000, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("bad_mask_no_write", last_data, 32'hA5A5_A5A5);

      do_txn(3'd0, 32'h1008, 3'd2, 4'hF, 32'h1122_3344, 1'b0, 0, 1'b0);
      do_txn(3'd2, 32'h1008, 3'd2, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      chk("bad_opcode_opcode", last_opcode, 3'd0);
      chk("bad_opcode_error", last_error, 1'b1);
      do_txn(3'd4, 32'h1008, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("bad_opcode_no_write", last_data, 32'h1122_3344);
      do_txn(3'd4, 32'h1002, 3'd2, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      chk("misaligned_error", last_error, 1'b1);

      // backpressure with a competing request held on the A channel
      do_txn(3'd4, 32'h1004, 3'd2, 4'hF, 32'h0, 1'b1, 5, 1'b1);
      chk("stall_get_data", last_data, 32'hFFFF_5678);
      chk("a_ready_after_stall", a_ready, 1'b1);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3)      op = 3'd0;
         else if (r < 6) op = 3'd1;
         else if (r < 9) op = 3'd4;
         else            op = 3'($urandom_range(5, 8) % 8 == 0 ? 2 : $urandom_range(5, 7));
         r = $urandom_range(0, 9);
         if (r < 7)       ad = 32'h1000 + 4 * $urandom_range(0, 15);
         else if (r == 7) ad = 32'h1000 + $urandom_range(0, 63);
         else if (r == 8) ad = ($urandom_range(0, 1) == 0) ? 32'h0FFC : 32'h1040;
         else             ad = $urandom;
         sz = ($urandom_range(0, 4) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
         mk = (op == 3'd0 && $urandom_range(0, 9) != 0) ? 4'hF : 4'($urandom);
         do_txn(op, ad, sz, mk, $urandom, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // reset while a Get response is pending
      do_txn(3'd0, 32'h1000, 3'd2, 4'hF, 32'h5555_AAAA, 1'b0, 0, 1'b0);
      a_valid = 1'b1; a_opcode = 3'd4; a_address = 32'h1000; a_size = 3'd2; a_source = 1'b1;
      @(posedge clk); #1;
      model_accept(3'd4, 32'h1000, 3'd2, 4'hF, 32'h0, 1'b1);
      a_valid = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1 chk("reset_kills_d_valid", d_valid, 1'b0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      fields_known = 1'b0;
      @(posedge clk); #1;
      exp_a_ready = 1'b1;
      chk("a_ready_after_mid_reset", a_ready, 1'b1);
      do_txn(3'd4, 32'h1000, 3'd2, 4'hF, 32'h0, 1'b1, 0, 1'b0);
      chk("mem_cleared_by_reset", last_data, 32'h0);
      chk("source_echo", last_source, 1'b1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
